// File: rtl/wb_init_pkg.sv
// Shared types and constants for the Wishbone command initiator.
package wb_init_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    // Width of the wait counter; a disabled timeout still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/wb_cmd_initiator_if.sv
// Wishbone classic-cycle bus between the initiator (master) and a peripheral (slave).
interface wb_cmd_initiator_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = 4
);
    logic                  wbm_cyc_o;
    logic                  wbm_stb_o;
    logic                  wbm_we_o;
    logic [SEL_WIDTH-1:0]  wbm_sel_o;
    logic [ADDR_WIDTH-1:0] wbm_adr_o;
    logic [DATA_WIDTH-1:0] wbm_dat_o;
    logic [DATA_WIDTH-1:0] wbm_dat_i;
    logic                  wbm_ack_i;
    logic                  wbm_err_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/wb_init_cmd_fifo.sv
// Synchronous command FIFO; head entry is read straight from the storage registers.
module wb_init_cmd_fifo #(
    parameter int unsigned WIDTH = 69,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_wr;
    logic             do_rd;

    // A push is refused whenever full, even if a pop happens on the same edge.
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (count == (PW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic-cycle initiator: queued single read/write commands in, one
// response per command out, strictly in order.
module wb_cmd_initiator
    import wb_init_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SEL_WIDTH      = 4,
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic [1:0]            rsp_status_o,
    output logic                  busy_o,
    wb_cmd_initiator_if.master    wbm
);
    localparam int unsigned    CMD_W   = 1 + ADDR_WIDTH + DATA_WIDTH + SEL_WIDTH;
    localparam int unsigned    TW      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  T_LIMIT = TW'(TIMEOUT_CYCLES);

    state_t                state;
    state_t                state_nxt;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [CMD_W-1:0]      fifo_head;

    logic                  we_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic [TW-1:0]         tcnt;
    logic [TW-1:0]         tcnt_inc;
    logic                  timeout_hit;

    logic                  rsp_load;
    logic [DATA_WIDTH-1:0] rsp_dat_q;
    logic [DATA_WIDTH-1:0] rsp_dat_nxt;
    logic [1:0]            rsp_status_q;
    logic [1:0]            rsp_status_nxt;

    wb_init_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .wr_en   (cmd_valid_i),
        .wr_data ({cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i}),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign cmd_ready_o = !fifo_full;
    assign tcnt_inc    = tcnt + 1'b1;
    // tcnt counts completed REQ cycles, so the limit is hit on the last allowed one.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_inc == T_LIMIT);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        fifo_pop       = 1'b0;
        rsp_load       = 1'b0;
        rsp_dat_nxt    = '0;
        rsp_status_nxt = ST_OK;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // err takes priority over a simultaneous ack and discards read data.
                if (wbm.wbm_err_i) begin
                    rsp_load       = 1'b1;
                    rsp_status_nxt = ST_ERR;
                    state_nxt      = RSP;
                end else if (wbm.wbm_ack_i) begin
                    rsp_load       = 1'b1;
                    rsp_status_nxt = ST_OK;
                    rsp_dat_nxt    = we_q ? '0 : wbm.wbm_dat_i;
                    state_nxt      = RSP;
                end else if (timeout_hit) begin
                    rsp_load       = 1'b1;
                    rsp_status_nxt = ST_TIMEOUT;
                    state_nxt      = RSP;
                end
            end
            RSP: begin
                if (rsp_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            tcnt         <= '0;
            rsp_dat_q    <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            if (fifo_pop) begin
                {we_q, adr_q, dat_q, sel_q} <= fifo_head;
                tcnt <= '0;
            end else if (state == REQ) begin
                tcnt <= tcnt_inc;
            end
            if (rsp_load) begin
                rsp_dat_q    <= rsp_dat_nxt;
                rsp_status_q <= rsp_status_nxt;
            end
        end
    end

    assign wbm.wbm_cyc_o = (state == REQ);
    assign wbm.wbm_stb_o = (state == REQ);
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;
    assign wbm.wbm_sel_o = sel_q;

    assign rsp_valid_o  = (state == RSP);
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = rsp_status_q;
    assign busy_o       = !fifo_empty || (state != IDLE);

endmodule
